// File: rtl/ss_retire_sb_pkg.sv
// Shared types for the superscalar retire stage and its committed-store buffer.
package ss_retire_sb_pkg;

  localparam int SB_XLEN      = 32;
  localparam int SB_DEPTH_DEF = 4;
  localparam int PRF_SIZE     = 64;
  localparam int RF_SIZE      = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Store access size as carried in funct3[1:0]
  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    DOUBLE = 2'b11
  } MEM_SIZE;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } R_TYPE;

  typedef struct packed {
    logic [6:0] off;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] set;
    logic [6:0] opcode;
  } S_TYPE;

  typedef union packed {
    logic [31:0] raw;
    R_TYPE       r;
    S_TYPE       s;
  } INST;

  typedef struct packed {
    INST  inst;
    logic rd_mem;
    logic wr_mem;
    logic halt;
  } PACKET;

  typedef struct packed {
    PACKET                         packet;
    logic [$clog2(PRF_SIZE)-1:0]   tag;
    logic [$clog2(PRF_SIZE)-1:0]   tag_old;
    logic [$clog2(RF_SIZE)-1:0]    dest;
  } ROB_ENTRY;

  // One committed store: 8-byte line address, lane-positioned data, byte enables
  typedef struct packed {
    logic [SB_XLEN-4:0] addr;
    logic [63:0]        data;
    logic [7:0]         be;
  } SB_ENTRY;

endpackage

// File: rtl/ss_store_fifo.sv
// Circular store FIFO: up to WIDTH pushes and one pop per cycle, with a
// per-entry line-address match vector for load probing.
module ss_store_fifo
  import ss_retire_sb_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            push_valid,
  input  SB_ENTRY                     push_entry [WIDTH],
  input  logic                        pop,
  input  logic [SB_XLEN-4:0]          ld_line,
  output SB_ENTRY                     head_entry,
  output logic [$clog2(SB_DEPTH):0]   count,
  output logic [SB_DEPTH-1:0]         ld_match
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  SB_ENTRY             mem_q [SB_DEPTH];
  SB_ENTRY             mem_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pop_ok;

  assign pop_ok = pop && (count_q != '0);

  // Pop the head, then pack the pushing slots into consecutive tail entries.
  // Pushes never land on the popped entry since no drain credit is given.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    count_d = count_q;
    wr_ptr  = tail_q;
    if (pop_ok) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      count_d         = count_d - 1'b1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (push_valid[i]) begin
        mem_d[wr_ptr]   = push_entry[i];
        valid_d[wr_ptr] = 1'b1;
        wr_ptr          = wr_ptr + 1'b1;
        count_d         = count_d + 1'b1;
      end
    end
    tail_d = wr_ptr;
  end

  // Control state: pointers, occupancy and valid bits, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q so no reset needed
  always_ff @(posedge clock) begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
    assign ld_match[gi] = valid_q[gi] && (mem_q[gi].addr == ld_line);
  end

endmodule

// File: rtl/ss_retire_sb.sv
// Superscalar retire stage: retires an in-order prefix of the ROB head and
// turns retiring stores into byte-masked 64-bit writes for the store buffer.
module ss_retire_sb
  import ss_retire_sb_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int XLEN     = SB_XLEN
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [WIDTH-1:0]                         rtr,
  input  ROB_ENTRY [WIDTH-1:0]                     rob_head,
  input  logic [WIDTH-1:0][XLEN-1:0]               st_addr,
  input  logic [WIDTH-1:0][XLEN-1:0]               st_data,
  output logic [WIDTH-1:0]                         inst_retire,
  output logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0]   preg,
  output logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0]   pregold,
  output logic [WIDTH-1:0][$clog2(RF_SIZE)-1:0]    dest_reg,
  output logic [WIDTH-1:0]                         halt,
  output logic [WIDTH-1:0]                         retire_load,
  output logic                                     dc_req_valid,
  output logic [63:0]                              dc_req_addr,
  output logic [63:0]                              dc_req_data,
  output logic [7:0]                               dc_req_be,
  input  logic                                     dc_req_ready,
  input  logic [XLEN-1:0]                          ld_addr,
  output logic                                     ld_conflict,
  output logic                                     sb_empty,
  output logic [$clog2(SB_DEPTH):0]                sb_count
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  SB_ENTRY             push_entry [WIDTH];
  SB_ENTRY             head_entry;
  logic [WIDTH-1:0]    push_valid;
  logic [SB_DEPTH-1:0] ld_match;
  logic [CNT_W-1:0]    free_slots, st_seen;
  logic                prefix_ok, slot_ok;
  logic                unused_bits;

  assign unused_bits = ^{rob_head, ld_addr[2:0]};
  assign sb_empty    = (sb_count == '0);
  assign free_slots  = CNT_W'(SB_DEPTH) - sb_count;

  // In-order retire prefix: stores need room counted against the registered
  // occupancy; a halt needs an empty buffer and no older store in the bundle.
  always_comb begin
    inst_retire = '0;
    halt        = '0;
    retire_load = '0;
    push_valid  = '0;
    st_seen     = '0;
    prefix_ok   = 1'b1;
    slot_ok     = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      slot_ok = 1'b1;
      if (rob_head[j].packet.halt) begin
        slot_ok = sb_empty && (st_seen == '0);
      end else if (rob_head[j].packet.wr_mem) begin
        slot_ok = (st_seen + 1'b1) <= free_slots;
      end
      if (prefix_ok && rtr[j] && slot_ok) begin
        inst_retire[j] = 1'b1;
        halt[j]        = rob_head[j].packet.halt;
        retire_load[j] = rob_head[j].packet.rd_mem;
        push_valid[j]  = rob_head[j].packet.wr_mem && !rob_head[j].packet.halt;
        if (rob_head[j].packet.halt) begin
          prefix_ok = 1'b0;
        end
      end else begin
        prefix_ok = 1'b0;
      end
      if (rob_head[j].packet.wr_mem) begin
        st_seen = st_seen + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
    logic [7:0]  size_mask;
    logic [63:0] lane_mask;
    logic [2:0]  offset;
    logic [63:0] lane_data;
    SB_ENTRY     entry;

    assign preg[gi]     = rob_head[gi].tag;
    assign pregold[gi]  = rob_head[gi].tag_old;
    assign dest_reg[gi] = rob_head[gi].dest;

    // Size-aligned offset and byte/data masks; size code 3 behaves as a word
    always_comb begin
      case (MEM_SIZE'(rob_head[gi].packet.inst.r.funct3[1:0]))
        BYTE: begin
          size_mask = 8'h01;
          lane_mask = 64'h0000_0000_0000_00FF;
          offset    = st_addr[gi][2:0];
        end
        HALF: begin
          size_mask = 8'h03;
          lane_mask = 64'h0000_0000_0000_FFFF;
          offset    = {st_addr[gi][2:1], 1'b0};
        end
        default: begin
          size_mask = 8'h0F;
          lane_mask = 64'h0000_0000_FFFF_FFFF;
          offset    = {st_addr[gi][2], 2'b00};
        end
      endcase
    end

    assign lane_data  = {{(64-XLEN){1'b0}}, st_data[gi]} & lane_mask;
    assign entry.addr = st_addr[gi][XLEN-1:3];
    assign entry.be   = size_mask << offset;
    assign entry.data = (rob_head[gi].packet.inst.s.rs2 == ZERO_REG) ? 64'd0
                                                                     : (lane_data << {offset, 3'b000});
    assign push_entry[gi] = entry;
  end

  ss_store_fifo #(
    .WIDTH    (WIDTH),
    .SB_DEPTH (SB_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_entry (push_entry),
    .pop        (dc_req_valid && dc_req_ready),
    .ld_line    (ld_addr[XLEN-1:3]),
    .head_entry (head_entry),
    .count      (sb_count),
    .ld_match   (ld_match)
  );

  assign dc_req_valid = (sb_count != '0);
  assign dc_req_addr  = 64'({head_entry.addr, 3'b000});
  assign dc_req_data  = head_entry.data;
  assign dc_req_be    = head_entry.be;
  assign ld_conflict  = |ld_match;

endmodule

// File: tb/tb_ss_retire_sb.sv
// Directed bench for ss_retire_sb: a table of per-cycle vectors plus an
// asynchronous-reset-mid-handshake sequence.
module tb_ss_retire_sb;
  import ss_retire_sb_pkg::*;

  logic                  clock, reset;
  logic [1:0]            rtr;
  ROB_ENTRY [1:0]        rob_head;
  logic [1:0][31:0]      st_addr, st_data;
  logic [1:0]            inst_retire, halt, retire_load;
  logic [1:0][5:0]       preg, pregold;
  logic [1:0][4:0]       dest_reg;
  logic                  dc_req_valid, dc_req_ready, ld_conflict, sb_empty;
  logic [63:0]           dc_req_addr, dc_req_data;
  logic [7:0]            dc_req_be;
  logic [31:0]           ld_addr;
  logic [2:0]            sb_count;

  int checks = 0;
  int errors = 0;

  ss_retire_sb #(.WIDTH(2), .SB_DEPTH(4), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .rtr(rtr), .rob_head(rob_head),
    .st_addr(st_addr), .st_data(st_data), .inst_retire(inst_retire),
    .preg(preg), .pregold(pregold), .dest_reg(dest_reg), .halt(halt),
    .retire_load(retire_load), .dc_req_valid(dc_req_valid),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_be(dc_req_be),
    .dc_req_ready(dc_req_ready), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]  rtr;
    ROB_ENTRY    e0, e1;
    logic [31:0] a0, d0, a1, d1;
    logic        rdy;
    logic [31:0] ld;
    logic [1:0]  xr, xrl, xh;
    logic        xv;
    logic [63:0] xaddr, xdata;
    logic [7:0]  xbe;
    logic [2:0]  xcnt;
    logic        xconf;
  } vec_t;

  vec_t vt [25];

  function automatic ROB_ENTRY mk(input logic [2:0] f3, input logic [4:0] rs2,
                                  input logic rd, input logic wr, input logic h);
    ROB_ENTRY e;
    e = '0;
    e.packet.inst.r.funct3 = f3;
    e.packet.inst.r.rs2    = rs2;
    e.packet.rd_mem        = rd;
    e.packet.wr_mem        = wr;
    e.packet.halt          = h;
    e.tag                  = 6'd9;
    e.tag_old              = 6'd12;
    e.dest                 = 5'd3;
    return e;
  endfunction

  function automatic vec_t mkv(
      input logic [1:0] r, input ROB_ENTRY e0, input logic [31:0] a0, input logic [31:0] d0,
      input ROB_ENTRY e1, input logic [31:0] a1, input logic [31:0] d1,
      input logic rdy, input logic [31:0] ld, input logic [1:0] xr, input logic [1:0] xrl,
      input logic [1:0] xh, input logic xv, input logic [63:0] xaddr, input logic [63:0] xdata,
      input logic [7:0] xbe, input logic [2:0] xcnt, input logic xconf);
    vec_t v;
    v.rtr = r; v.e0 = e0; v.a0 = a0; v.d0 = d0; v.e1 = e1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.ld = ld; v.xr = xr; v.xrl = xrl; v.xh = xh; v.xv = xv;
    v.xaddr = xaddr; v.xdata = xdata; v.xbe = xbe; v.xcnt = xcnt; v.xconf = xconf;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
    end
  endtask

  ROB_ENTRY alu_e, ld_e, sb_e, sw_e, sh0_e, hlt_e;

  initial begin
    alu_e = mk(3'b000, 5'd1, 1'b0, 1'b0, 1'b0);
    ld_e  = mk(3'b010, 5'd0, 1'b1, 1'b0, 1'b0);
    sb_e  = mk(3'b000, 5'd5, 1'b0, 1'b1, 1'b0);
    sw_e  = mk(3'b010, 5'd6, 1'b0, 1'b1, 1'b0);
    sh0_e = mk(3'b001, 5'd0, 1'b0, 1'b1, 1'b0);
    hlt_e = mk(3'b000, 5'd0, 1'b0, 1'b0, 1'b1);

    //            rtr    e0     a0          d0            e1     a1          d1            rdy ld          xr     xrl    xh     xv  xaddr        xdata                  xbe    xcnt  xconf
    vt[0]  = mkv(2'b11, sb_e,  32'h1005, 32'hAB,       ld_e,  32'h0,    32'h0,        0, 32'h0,    2'b11, 2'b10, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[1]  = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h1000, 64'h0000AB0000000000, 8'h20, 3'd1, 0);
    vt[2]  = mkv(2'b11, sw_e,  32'h2000, 32'h11111111, sw_e,  32'h2004, 32'h22222222, 0, 32'h0,    2'b11, 2'b00, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[3]  = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h2000, 64'h0000000011111111, 8'h0F, 3'd2, 0);
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h2000, 64'h0000000011111111, 8'h0F, 3'd2, 0);
    vt[7]  = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h2000, 64'h2222222200000000, 8'hF0, 3'd1, 0);
    vt[8]  = mkv(2'b11, sw_e,  32'h4000, 32'h1,        sw_e,  32'h400A, 32'h2,        0, 32'h0,    2'b11, 2'b00, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[9]  = mkv(2'b11, sw_e,  32'h4010, 32'h3,        sw_e,  32'h4018, 32'h4,        0, 32'h0,    2'b11, 2'b00, 2'b00, 1, 64'h4000, 64'h1,                 8'h0F, 3'd2, 0);
    vt[10] = mkv(2'b11, alu_e, 32'h0,    32'h0,        sw_e,  32'h4020, 32'h5,        0, 32'h0,    2'b01, 2'b00, 2'b00, 1, 64'h4000, 64'h1,                 8'h0F, 3'd4, 0);
    vt[11] = mkv(2'b11, alu_e, 32'h0,    32'h0,        sw_e,  32'h4020, 32'h5,        1, 32'h0,    2'b01, 2'b00, 2'b00, 1, 64'h4000, 64'h1,                 8'h0F, 3'd4, 0);
    vt[12] = mkv(2'b01, sw_e,  32'h4020, 32'h5,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b01, 2'b00, 2'b00, 1, 64'h4008, 64'h2,                 8'h0F, 3'd3, 0);
    vt[13] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h4010, 64'h3,                 8'h0F, 3'd3, 0);
    vt[14] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h4018, 64'h4,                 8'h0F, 3'd2, 0);
    vt[15] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h4020, 64'h5,                 8'h0F, 3'd1, 0);
    vt[16] = mkv(2'b01, sw_e,  32'h5000, 32'h77,       alu_e, 32'h0,    32'h0,        0, 32'h0,    2'b01, 2'b00, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[17] = mkv(2'b11, hlt_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h5000, 64'h77,                8'h0F, 3'd1, 0);
    vt[18] = mkv(2'b11, hlt_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h0,    2'b00, 2'b00, 2'b00, 1, 64'h5000, 64'h77,                8'h0F, 3'd1, 0);
    vt[19] = mkv(2'b11, hlt_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h0,    2'b01, 2'b00, 2'b01, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[20] = mkv(2'b01, sh0_e, 32'h3002, 32'hFFFF,     alu_e, 32'h0,    32'h0,        0, 32'h3006, 2'b01, 2'b00, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);
    vt[21] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h3006, 2'b00, 2'b00, 2'b00, 1, 64'h3000, 64'h0,                 8'h0C, 3'd1, 1);
    vt[22] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h3008, 2'b00, 2'b00, 2'b00, 1, 64'h3000, 64'h0,                 8'h0C, 3'd1, 0);
    vt[23] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        1, 32'h3006, 2'b00, 2'b00, 2'b00, 1, 64'h3000, 64'h0,                 8'h0C, 3'd1, 1);
    vt[24] = mkv(2'b00, alu_e, 32'h0,    32'h0,        alu_e, 32'h0,    32'h0,        0, 32'h3006, 2'b00, 2'b00, 2'b00, 0, 64'h0,    64'h0,                 8'h00, 3'd0, 0);

    // Reset state
    reset = 1'b1; rtr = '0; rob_head[0] = alu_e; rob_head[1] = alu_e;
    st_addr = '0; st_data = '0; dc_req_ready = 1'b0; ld_addr = '0;
    @(negedge clock);
    #1;
    chk("rst_valid", -1, 64'(dc_req_valid), 64'd0);
    chk("rst_count", -1, 64'(sb_count), 64'd0);
    chk("rst_empty", -1, 64'(sb_empty), 64'd1);
    chk("rst_conf",  -1, 64'(ld_conflict), 64'd0);
    chk("preg1",     -1, 64'(preg[1]), 64'd9);
    chk("pregold1",  -1, 64'(pregold[1]), 64'd12);
    chk("dest1",     -1, 64'(dest_reg[1]), 64'd3);
    @(negedge clock);
    reset = 1'b0;

    // Per-cycle vector table
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      rtr = vt[i].rtr; rob_head[0] = vt[i].e0; rob_head[1] = vt[i].e1;
      st_addr[0] = vt[i].a0; st_data[0] = vt[i].d0;
      st_addr[1] = vt[i].a1; st_data[1] = vt[i].d1;
      dc_req_ready = vt[i].rdy; ld_addr = vt[i].ld;
      #1;
      chk("retire", i, 64'(inst_retire), 64'(vt[i].xr));
      chk("rload",  i, 64'(retire_load), 64'(vt[i].xrl));
      chk("halt",   i, 64'(halt), 64'(vt[i].xh));
      chk("valid",  i, 64'(dc_req_valid), 64'(vt[i].xv));
      chk("count",  i, 64'(sb_count), 64'(vt[i].xcnt));
      chk("empty",  i, 64'(sb_empty), 64'(vt[i].xcnt == 3'd0));
      chk("conf",   i, 64'(ld_conflict), 64'(vt[i].xconf));
      if (vt[i].xv) begin
        chk("addr", i, dc_req_addr, vt[i].xaddr);
        chk("data", i, dc_req_data, vt[i].xdata);
        chk("be",   i, 64'(dc_req_be), 64'(vt[i].xbe));
      end
      $display("row %0d rtr=%b retire=%b valid=%b addr=%h be=%h count=%0d conf=%b",
               i, rtr, inst_retire, dc_req_valid, dc_req_addr, dc_req_be, sb_count, ld_conflict);
    end

    // Asynchronous reset while a request is stalled
    @(negedge clock);
    rtr = 2'b01; rob_head[0] = sw_e; rob_head[1] = alu_e;
    st_addr[0] = 32'h6004; st_data[0] = 32'h5A; dc_req_ready = 1'b0; ld_addr = 32'h6000;
    #1;
    chk("ar_retire", 100, 64'(inst_retire), 64'd1);
    @(negedge clock);
    rtr = 2'b00;
    #1;
    chk("ar_valid_pre", 101, 64'(dc_req_valid), 64'd1);
    chk("ar_conf_pre",  101, 64'(ld_conflict), 64'd1);
    chk("ar_be_pre",    101, 64'(dc_req_be), 64'hF0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 102, 64'(dc_req_valid), 64'd0);
    chk("ar_count", 102, 64'(sb_count), 64'd0);
    chk("ar_empty", 102, 64'(sb_empty), 64'd1);
    chk("ar_conf",  102, 64'(ld_conflict), 64'd0);
    $display("async reset mid-handshake valid=%b count=%0d", dc_req_valid, sb_count);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ar_count_post", 103, 64'(sb_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
